// File: rtl/abro_n_if.sv
// Reactive port bundle for abro_n: restart and event inputs; completion, progress, halt and count outputs.
// The master drives R/A; the slave (the controller) drives O/seen/halted/count.
interface abro_n_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  logic             R;
  logic [N-1:0]     A;
  logic             O;
  logic [N-1:0]     seen;
  logic             halted;
  logic [CNT_W-1:0] count;

  modport master (output R, A, input O, seen, halted, count);
  modport slave  (input R, A, output O, seen, halted, count);
endinterface

// File: rtl/abro_n.sv
// N-input ABRO controller: awaits all events (any or index order), pulses O (Mealy, same instant), halts until R.
// Optional completion counter under ABRO_N_COUNT_EN; no backpressure, one reaction per clk edge.
module abro_n #(
  parameter int N       = 2,
  parameter int ORDERED = 0,
  parameter int CNT_W   = 8
) (
  input  logic   clk,
  input  logic   rst,
  abro_n_if.slave bus
);

  typedef enum logic [1:0] {BOOT, WAIT, DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_seen;
  logic [N-1:0]   w_seen_nxt;
  logic           r_halted;
  logic           w_o;
  logic [N-1:0]   w_hit_any;
  logic [N-1:0]   w_low;
  logic [N-1:0]   w_hit_ord;
  logic [N-1:0]   w_hit;
  logic           w_all;

  // Ordered mode: seen is always a prefix, so its lowest clear bit is the only acceptable event.
  assign w_hit_any = r_seen | bus.A;
  assign w_low     = ~r_seen & (r_seen + N'(1));
  assign w_hit_ord = r_seen | (w_low & bus.A);
  assign w_hit     = (ORDERED != 0) ? w_hit_ord : w_hit_any;
  assign w_all     = (ORDERED != 0) ? w_hit_ord[N-1] : (&w_hit_any);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= BOOT;
      r_seen   <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_seen   <= w_seen_nxt;
      r_halted <= (w_state_nxt == DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seen_nxt  = r_seen;
    w_o         = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = WAIT;
      WAIT: begin
        if (bus.R) begin
          w_seen_nxt = '0;
        end else if (w_all) begin
          w_o         = 1'b1;
          w_state_nxt = DONE;
          w_seen_nxt  = '0;
        end else begin
          w_seen_nxt = w_hit;
        end
      end
      DONE: begin
        if (bus.R) begin
          w_state_nxt = WAIT;
          w_seen_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = BOOT;
        w_seen_nxt  = '0;
      end
    endcase
  end

  assign bus.O      = w_o;
  assign bus.seen   = r_seen;
  assign bus.halted = r_halted;

`ifdef ABRO_N_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Saturating; R deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_o && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.count = r_count;
`else
  assign bus.count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_abro_n.sv
// Bench for abro_n: three instances (N=2 any-order, N=4 any-order, N=3 ordered) share clk/rst.
// Driver pushes expected values from a progress-level model; a monitor pops and compares every instant.
module tb_abro_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  abro_n_if #(.N(2), .CNT_W(2)) b0 ();
  abro_n_if #(.N(4), .CNT_W(8)) b1 ();
  abro_n_if #(.N(3), .CNT_W(8)) b2 ();

  abro_n #(.N(2), .ORDERED(0), .CNT_W(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  abro_n #(.N(4), .ORDERED(0), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  abro_n #(.N(3), .ORDERED(1), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct packed {
    logic [1:0]  id;
    logic        o;
    logic [31:0] seen;
    logic        halted;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int   p_n[3]    = '{2, 4, 3};
  bit   p_ord[3]  = '{1'b0, 1'b0, 1'b1};
  int   p_cmax[3] = '{3, 255, 255};

  // Model state: boot/done flags, unordered event set, ordered progress length, completions.
  bit          m_boot[3];
  bit          m_done[3];
  logic [31:0] m_set[3];
  int          m_prog[3];
  int          m_cnt[3];

  task automatic model(input int id, input logic rn, input logic r, input logic [31:0] a);
    logic [31:0] mask;
    logic [31:0] hit;
    logic [31:0] shown;
    logic        o;
    exp_t        e;
    mask = (32'd1 << p_n[id]) - 32'd1;
    if (!rn) begin
      m_boot[id] = 1'b1;
      m_done[id] = 1'b0;
      m_set[id]  = '0;
      m_prog[id] = 0;
      m_cnt[id]  = 0;
    end
    shown = p_ord[id] ? ((32'd1 << m_prog[id]) - 32'd1) : m_set[id];
    hit   = (m_set[id] | a) & mask;
    o     = 1'b0;
    if (rn && !m_boot[id] && !r && !m_done[id]) begin
      if (p_ord[id]) o = a[m_prog[id]] && (m_prog[id] == p_n[id] - 1);
      else           o = (hit == mask);
    end
    e.id     = 2'(id);
    e.o      = o;
    e.seen   = shown;
    e.halted = m_done[id];
    e.cnt    = 8'(m_cnt[id]);
    q.push_back(e);
    if (rn) begin
      if (m_boot[id]) begin
        m_boot[id] = 1'b0;
      end else if (r) begin
        m_set[id]  = '0;
        m_prog[id] = 0;
        m_done[id] = 1'b0;
      end else if (!m_done[id]) begin
        if (p_ord[id]) begin
          if (a[m_prog[id]]) m_prog[id]++;
          if (m_prog[id] == p_n[id]) begin
            m_prog[id] = 0;
            m_done[id] = 1'b1;
          end
        end else if (o) begin
          m_set[id]  = '0;
          m_done[id] = 1'b1;
        end else begin
          m_set[id] = hit;
        end
      end
`ifdef ABRO_N_COUNT_EN
      if (o && m_cnt[id] < p_cmax[id]) m_cnt[id]++;
`endif
    end
  endtask

  task automatic step(input logic rn,
                      input logic r0, input logic [1:0] a0,
                      input logic r1, input logic [3:0] a1,
                      input logic r2, input logic [2:0] a2);
    @(negedge clk);
    cyc++;
    rst  = rn;
    b0.R = r0; b0.A = a0;
    b1.R = r1; b1.A = a1;
    b2.R = r2; b2.A = a2;
    model(0, rn, r0, 32'(a0));
    model(1, rn, r1, 32'(a1));
    model(2, rn, r2, 32'(a2));
  endtask

  // Monitor: mid-cycle sample, after inputs settle and before the next rising edge.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        act.id = e.id;
        case (e.id)
          2'd0:    begin act.o = b0.O; act.seen = 32'(b0.seen); act.halted = b0.halted; act.cnt = 8'(b0.count); end
          2'd1:    begin act.o = b1.O; act.seen = 32'(b1.seen); act.halted = b1.halted; act.cnt = 8'(b1.count); end
          default: begin act.o = b2.O; act.seen = 32'(b2.seen); act.halted = b2.halted; act.cnt = 8'(b2.count); end
        endcase
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL inst%0d cyc%0d: got O=%b seen=%h halted=%b count=%0d, want O=%b seen=%h halted=%b count=%0d",
                   e.id, cyc, act.o, act.seen, act.halted, act.cnt, e.o, e.seen, e.halted, e.cnt);
        end
      end
    end
  end

  initial begin
    b0.R = 1'b0; b0.A = '0;
    b1.R = 1'b0; b1.A = '0;
    b2.R = 1'b0; b2.A = '0;
    repeat (3) step(1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b000);

    // BOOT ignores events; then split events, all-at-once, ordered sequence, held-high inputs.
    step(1'b1, 1'b0, 2'b11, 1'b0, 4'hF, 1'b0, 3'b111);
    step(1'b1, 1'b0, 2'b01, 1'b0, 4'hF, 1'b0, 3'b100);
    step(1'b1, 1'b0, 2'b10, 1'b0, 4'hF, 1'b0, 3'b010);
    step(1'b1, 1'b0, 2'b11, 1'b0, 4'hF, 1'b0, 3'b001);
    step(1'b1, 1'b0, 2'b11, 1'b0, 4'hF, 1'b0, 3'b010);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'hF, 1'b0, 3'b100);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'hF, 1'b0, 3'b111);

    // R priority over a same-instant event; ordered held-high input advances one bit per instant.
    step(1'b1, 1'b1, 2'b00, 1'b1, 4'h0, 1'b1, 3'b000);
    step(1'b1, 1'b0, 2'b01, 1'b0, 4'h3, 1'b0, 3'b001);
    step(1'b1, 1'b1, 2'b10, 1'b1, 4'hC, 1'b0, 3'b010);
    step(1'b1, 1'b0, 2'b11, 1'b0, 4'h5, 1'b0, 3'b000);
    step(1'b1, 1'b1, 2'b00, 1'b0, 4'hA, 1'b1, 3'b111);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b111);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b111);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b111);

    // Reach seen=011 on the ordered instance, then drop rst between edges.
    step(1'b1, 1'b1, 2'b00, 1'b1, 4'h0, 1'b1, 3'b000);
    step(1'b1, 1'b0, 2'b01, 1'b0, 4'h7, 1'b0, 3'b001);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b010);
    step(1'b0, 1'b0, 2'b11, 1'b0, 4'hF, 1'b0, 3'b111);
    step(1'b1, 1'b0, 2'b11, 1'b0, 4'hF, 1'b0, 3'b111);
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b000);

    // Five completions with R between them: exercises counter saturation on the 2-bit instance.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 2'b11, 1'b0, 4'hF, 1'b0, 3'b111);
      step(1'b1, 1'b1, 2'b00, 1'b1, 4'h0, 1'b1, 3'b000);
    end
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b000);
    step(1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 3'b000);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 7) == 0, 2'($urandom),
           $urandom_range(0, 9) == 0, 4'($urandom),
           $urandom_range(0, 7) == 0, 3'($urandom));
    end

    @(negedge clk);
    #4;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
